// File: rtl/scanline_gen.sv
// Scanline overlay stage: darkens selected rows/columns of the active picture.
// Pixels, syncs, DE and coordinates all leave exactly PIPE_LAT cycles later.
module scanline_gen #(
    parameter int PIPE_LAT = 3
) (
    input  logic        PCLK_i,
    input  logic        reset_n,
    input  logic [7:0]  R_i,
    input  logic [7:0]  G_i,
    input  logic [7:0]  B_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    input  logic [10:0] xpos_i,
    input  logic [10:0] ypos_i,
    input  logic [31:0] sl_config,
    input  logic [31:0] sl_config2,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic [10:0] xpos_o,
    output logic [10:0] ypos_o
);

    logic [3:0] h_str, v_str;
    logic [7:0] h_mask, v_mask;
    logic [2:0] h_pm1, v_pm1, h_phase, v_phase;
    logic       h_en, v_en;

    assign h_str   = sl_config[3:0];
    assign v_str   = sl_config[7:4];
    assign h_mask  = sl_config[15:8];
    assign h_pm1   = sl_config[18:16];
    assign v_pm1   = sl_config[21:19];
    assign v_mask  = sl_config[29:22];
    assign h_en    = sl_config[30];
    assign v_en    = sl_config[31];
    assign h_phase = sl_config2[2:0];
    assign v_phase = sl_config2[5:3];

    logic unused_cfg2;
    assign unused_cfg2 = ^sl_config2[31:6];

    logic [2:0]  y_ph, x_ph, y_cur, x_cur, h_ld, v_ld;
    logic [10:0] ypos_prev;
    logic        line_start, h_hit, v_hit, mod;
    logic [3:0]  str_sel;

    // Phase that applies to the pixel now at the input, plus hit decode
    always_comb begin
        line_start = DE_i && (xpos_i == 11'd0);
        h_ld = (h_phase > h_pm1) ? 3'd0 : h_phase;
        v_ld = (v_phase > v_pm1) ? 3'd0 : v_phase;
        y_cur = y_ph;
        if (line_start && (ypos_i == 11'd0))
            y_cur = h_ld;
        else if (line_start && (ypos_i != ypos_prev))
            y_cur = (y_ph >= h_pm1) ? 3'd0 : y_ph + 3'd1;
        x_cur = x_ph;
        if (line_start)
            x_cur = v_ld;
        else if (DE_i)
            x_cur = (x_ph >= v_pm1) ? 3'd0 : x_ph + 3'd1;
        h_hit = h_en && (y_cur <= h_pm1) && h_mask[y_cur];
        v_hit = v_en && (x_cur <= v_pm1) && v_mask[x_cur];
        mod = DE_i && (h_hit || v_hit);
        str_sel = 4'd0;
        if (h_hit && v_hit)
            str_sel = (h_str > v_str) ? h_str : v_str;
        else if (h_hit)
            str_sel = h_str;
        else if (v_hit)
            str_sel = v_str;
    end

    // Stage 0 state: line/column phase counters and last seen line
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            y_ph      <= 3'd0;
            x_ph      <= 3'd0;
            ypos_prev <= 11'd0;
        end else begin
            y_ph <= y_cur;
            x_ph <= x_cur;
            if (line_start)
                ypos_prev <= ypos_i;
        end
    end

    logic [PIPE_LAT-1:0] hs_d, vs_d, de_d;
    logic [10:0]         x_d [PIPE_LAT];
    logic [10:0]         y_d [PIPE_LAT];

    // Plain delay line for syncs, DE and coordinates
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            hs_d <= '1;
            vs_d <= '1;
            de_d <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                x_d[i] <= 11'd0;
                y_d[i] <= 11'd0;
            end
        end else begin
            hs_d <= {hs_d[PIPE_LAT-2:0], HSYNC_i};
            vs_d <= {vs_d[PIPE_LAT-2:0], VSYNC_i};
            de_d <= {de_d[PIPE_LAT-2:0], DE_i};
            x_d[0] <= xpos_i;
            y_d[0] <= ypos_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                x_d[i] <= x_d[i-1];
                y_d[i] <= y_d[i-1];
            end
        end
    end

    assign HSYNC_o = hs_d[PIPE_LAT-1];
    assign VSYNC_o = vs_d[PIPE_LAT-1];
    assign DE_o    = de_d[PIPE_LAT-1];
    assign xpos_o  = x_d[PIPE_LAT-1];
    assign ypos_o  = y_d[PIPE_LAT-1];

    function automatic logic [12:0] scale(input logic [7:0] c,
                                          input logic [3:0] s);
        return 13'(c) * (13'(s) + 13'd1);
    endfunction

    function automatic logic [7:0] atten(input logic [7:0]  c,
                                         input logic [12:0] p);
        logic [8:0] d;
        d = {1'b0, c} - p[12:4];
        return d[7:0];
    endfunction

    logic [23:0] s1_rgb, s2_rgb;
    logic [3:0]  s1_str;
    logic        s1_mod, s2_mod;
    logic [12:0] s2_pr, s2_pg, s2_pb;

    // Pixel path: select strength, multiply, then subtract the scaled share
    always_ff @(posedge PCLK_i) begin
        if (!reset_n) begin
            s1_rgb <= 24'd0;
            s1_str <= 4'd0;
            s1_mod <= 1'b0;
            s2_rgb <= 24'd0;
            s2_mod <= 1'b0;
            s2_pr  <= 13'd0;
            s2_pg  <= 13'd0;
            s2_pb  <= 13'd0;
            R_o    <= 8'd0;
            G_o    <= 8'd0;
            B_o    <= 8'd0;
        end else begin
            s1_rgb <= {R_i, G_i, B_i};
            s1_str <= str_sel;
            s1_mod <= mod;
            s2_rgb <= s1_rgb;
            s2_mod <= s1_mod;
            s2_pr  <= scale(s1_rgb[23:16], s1_str);
            s2_pg  <= scale(s1_rgb[15:8], s1_str);
            s2_pb  <= scale(s1_rgb[7:0], s1_str);
            R_o <= s2_mod ? atten(s2_rgb[23:16], s2_pr) : s2_rgb[23:16];
            G_o <= s2_mod ? atten(s2_rgb[15:8], s2_pg) : s2_rgb[15:8];
            B_o <= s2_mod ? atten(s2_rgb[7:0], s2_pb) : s2_rgb[7:0];
        end
    end

endmodule

// File: tb/tb_scanline_gen.sv
// Directed bench for scanline_gen: reset, latency, H/V overlays,
// strength combining, phase clamping, mid-frame reset and blanking.
module tb_scanline_gen;

    logic        PCLK_i = 1'b0;
    logic        reset_n;
    logic [7:0]  R_i, G_i, B_i;
    logic        HSYNC_i, VSYNC_i, DE_i;
    logic [10:0] xpos_i, ypos_i;
    logic [31:0] sl_config, sl_config2;
    logic [7:0]  R_o, G_o, B_o;
    logic        HSYNC_o, VSYNC_o, DE_o;
    logic [10:0] xpos_o, ypos_o;

    scanline_gen #(.PIPE_LAT(3)) dut (
        .PCLK_i(PCLK_i), .reset_n(reset_n),
        .R_i(R_i), .G_i(G_i), .B_i(B_i),
        .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
        .xpos_i(xpos_i), .ypos_i(ypos_i),
        .sl_config(sl_config), .sl_config2(sl_config2),
        .R_o(R_o), .G_o(G_o), .B_o(B_o),
        .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
        .xpos_o(xpos_o), .ypos_o(ypos_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    int errors = 0;
    int checks = 0;
    int qe[$];
    int qd[$];
    int qh[$];
    int qx[$];
    int qy[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cfg(
        input bit hen, input bit ven, input int vmask, input int vpm1,
        input int hpm1, input int hmask, input int vstr, input int hstr);
        logic [31:0] v;
        v = {ven, hen, 8'(vmask), 3'(vpm1), 3'(hpm1),
             8'(hmask), 4'(vstr), 4'(hstr)};
        return v;
    endfunction

    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic qclear();
        qe.delete(); qd.delete(); qh.delete(); qx.delete(); qy.delete();
    endtask

    // Drive one pixel; check the pixel driven three cycles earlier
    task automatic pix(input bit de, input bit hs, input int x,
                       input int y, input int c, input int exp);
        int e, d, h, px, py;
        DE_i = de; HSYNC_i = hs; VSYNC_i = 1'b1;
        xpos_i = 11'(x); ypos_i = 11'(y);
        R_i = 8'(c); G_i = 8'(c); B_i = 8'(c);
        qe.push_back(exp); qd.push_back(int'(de)); qh.push_back(int'(hs));
        qx.push_back(x); qy.push_back(y);
        tick();
        if (qe.size() == 3) begin
            e = qe.pop_front(); d = qd.pop_front(); h = qh.pop_front();
            px = qx.pop_front(); py = qy.pop_front();
            chk("de_dly", int'(DE_o), d);
            chk("hs_dly", int'(HSYNC_o), h);
            chk("vs_dly", int'(VSYNC_o), 1);
            chk("x_dly", int'(xpos_o), px);
            chk("y_dly", int'(ypos_o), py);
            if (e >= 0) begin
                chk($sformatf("R x%0d y%0d", px, py), int'(R_o), e);
                chk($sformatf("G x%0d y%0d", px, py), int'(G_o), e);
                chk($sformatf("B x%0d y%0d", px, py), int'(B_o), e);
            end
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " R"}, int'(R_o), 0);
        chk({tag, " G"}, int'(G_o), 0);
        chk({tag, " B"}, int'(B_o), 0);
        chk({tag, " HS"}, int'(HSYNC_o), 1);
        chk({tag, " VS"}, int'(VSYNC_o), 1);
        chk({tag, " DE"}, int'(DE_o), 0);
        chk({tag, " X"}, int'(xpos_o), 0);
        chk({tag, " Y"}, int'(ypos_o), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b1, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        sl_config = 32'd0; sl_config2 = 32'd0;
        DE_i = 0; HSYNC_i = 1; VSYNC_i = 1;
        xpos_i = 0; ypos_i = 0; R_i = 0; G_i = 0; B_i = 0;

        // 1: reset with random inputs, then sync latency
        for (int i = 0; i < 5; i++) begin
            R_i = 8'($urandom); G_i = 8'($urandom); B_i = 8'($urandom);
            HSYNC_i = 1'($urandom); VSYNC_i = 1'($urandom);
            DE_i = 1'($urandom);
            xpos_i = 11'($urandom); ypos_i = 11'($urandom);
            tick();
            chk_reset_outs("rst");
        end
        reset_n = 1'b1;
        qclear();
        idle(3);
        pix(1'b0, 1'b0, 0, 0, 0, 0);
        idle(5);

        // 2: horizontal scanlines on odd lines, str 7
        sl_config = cfg(1, 0, 0, 0, 1, 8'b10, 0, 7);
        sl_config2 = 32'd0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 6; x++)
                pix(1'b1, 1'b1, x, y, 200, (y % 2) ? 100 : 200);
            pix(1'b0, 1'b1, 6, y, 200, 200);
            pix(1'b0, 1'b1, 7, y, 200, 200);
        end
        idle(3);

        // 3: vertical scanlines, period 3, phase 1, str 15
        sl_config = cfg(0, 1, 8'b001, 2, 0, 0, 15, 0);
        sl_config2 = 32'(1 << 3);
        for (int x = 0; x < 10; x++)
            pix(1'b1, 1'b1, x, 0, 255, (x % 3 == 2) ? 0 : 255);
        idle(3);

        // 4: both channels; even x both hit (max str 11), odd x H only
        sl_config = cfg(1, 1, 8'b01, 1, 0, 8'b1, 11, 3);
        sl_config2 = 32'd0;
        for (int x = 0; x < 6; x++)
            pix(1'b1, 1'b1, x, 0, 160, (x % 2) ? 120 : 40);
        idle(3);

        // 5: out-of-range phase clamps to 0; then mid-line reset
        sl_config = cfg(1, 0, 0, 0, 3, 8'b1, 0, 15);
        sl_config2 = 32'd5;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                pix(1'b1, 1'b1, x, y, 100, (y == 0) ? 0 : 100);
        pix(1'b1, 1'b1, 0, 2, 100, 100);
        pix(1'b1, 1'b1, 1, 2, 100, 100);
        reset_n = 1'b0;
        DE_i = 1'b1; HSYNC_i = 1'b0; xpos_i = 11'd2; R_i = 8'd77;
        tick();
        chk_reset_outs("midrst");
        reset_n = 1'b1;
        qclear();
        idle(4);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                pix(1'b1, 1'b1, x, y, 100, (y == 0) ? 0 : 100);
        idle(3);

        // 6: blanking passes through with every mask set
        sl_config = cfg(1, 1, 8'hff, 7, 7, 8'hff, 15, 15);
        sl_config2 = 32'd0;
        pix(1'b0, 1'b1, 0, 0, 90, 90);
        pix(1'b0, 1'b1, 3, 5, 150, 150);
        pix(1'b1, 1'b1, 0, 0, 90, 0);
        pix(1'b0, 1'b1, 1, 0, 222, 222);
        idle(3);

        // 6b: column phase holds across a DE=0 gap
        sl_config = cfg(0, 1, 8'b001, 2, 0, 0, 15, 0);
        sl_config2 = 32'(1 << 3);
        pix(1'b1, 1'b1, 0, 0, 255, 255);
        pix(1'b1, 1'b1, 1, 0, 255, 255);
        for (int i = 0; i < 4; i++)
            pix(1'b0, 1'b1, 5, 0, 255, 255);
        pix(1'b1, 1'b1, 2, 0, 255, 0);
        pix(1'b1, 1'b1, 3, 0, 255, 255);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scanline_gen.md
Name: scanline_gen

Overview:
Output-domain post-process stage placed directly downstream of the scan converter. It consumes RGB, sync, DE and xpos/ypos, and overlays horizontal and/or vertical scanlines with programmable period, line mask, phase and strength. All signals are delayed by a fixed latency so that sync and pixels stay aligned. The output feeds the video transmitter.

Parameters:
PIPE_LAT, 3, fixed pipeline latency in PCLK_i cycles; the only supported value is 3.

Ports:
PCLK_i  in  1  output pixel clock; single clock domain
reset_n  in  1  synchronous reset, active-low
R_i / G_i / B_i  in  8 each  input pixel components
HSYNC_i / VSYNC_i  in  1 each  active-low syncs
DE_i  in  1  data enable
xpos_i / ypos_i  in  11 each  active-area pixel coordinates
sl_config  in  32  [3:0] H_STR; [7:4] V_STR; [15:8] H_MASK; [18:16] H_PERIOD-1; [21:19] V_PERIOD-1; [29:22] V_MASK; [30] H_EN; [31] V_EN
sl_config2  in  32  [2:0] H_PHASE; [5:3] V_PHASE; others reserved
R_o / G_o / B_o  out  8 each  processed pixel
HSYNC_o / VSYNC_o / DE_o  out  1 each  delayed syncs and DE
xpos_o / ypos_o  out  11 each  delayed coordinates

Behaviour:
- Reset: the reset is sampled on the PCLK_i edge while reset_n = 0. During reset:
  - R_o, G_o, B_o = 0; HSYNC_o = 1; VSYNC_o = 1; DE_o = 0; xpos_o = 0; ypos_o = 0.
  - Phase counters and ypos_prev = 0.
- Latency: every output equals its input 3 cycles earlier. Sync, DE and coordinates pass through a plain 3-stage delay.
- Config sampling: config is sampled every cycle. Changes take effect at the next counter load; glitches mid-line are tolerated.
- Line phase counter y_ph (3 bit), stage 0:
  - Load: when DE_i=1 & xpos_i=0 & ypos_i=0, load H_PHASE, or 0 if H_PHASE > H_PERIOD-1.
  - Advance: else when DE_i=1 & xpos_i=0 & ypos_i != ypos_prev, increment.
  - Wrap: after H_PERIOD-1, return to 0.
  - ypos_prev updates on every DE_i=1 & xpos_i=0 cycle.
- Column phase counter x_ph (3 bit), stage 0:
  - Load: when DE_i=1 & xpos_i=0, load V_PHASE, clamped the same way.
  - Advance: else when DE_i=1, increment, wrapping after V_PERIOD-1.
  - Hold: otherwise hold.
- Hit decode (registered into stage 1), using the phase value that applies to the current pixel (the loaded value on the load cycle):
  - h_hit = H_EN & H_MASK[y_ph]
  - v_hit = V_EN & V_MASK[x_ph]
  - Mask bits at index >= period are never selected.
- Strength selection:
  - Both hit: str = max(H_STR, V_STR).
  - One hit: that channel's strength.
  - Neither hit, or DE=0: bypass.
- Arithmetic, per component c:
  - Stage 2: prod = c × (str+1), 13 bit unsigned.
  - Stage 3: out = c − prod[12:4].
  - str = 15 yields exactly 0. No underflow is possible, since prod>>4 ≤ c.
  - Bypass yields out = c unchanged.
- Blanking: DE=0 pixels are passed through unmodified.
- Simultaneous events: load has priority over advance for both counters.
- Mid-frame reset: state is clean after deassertion. y_ph is correct from the next ypos_i=0 line.
- Before the first load, y_ph may be stale. A frame that never presents ypos_i=0 keeps free-running increments.

Test Plan:
1. Reset held for 5 cycles with random inputs → R_o=G_o=B_o=0, HSYNC_o=VSYNC_o=1, DE_o=0. After release, an input pulse on HSYNC_i appears on HSYNC_o exactly 3 cycles later.
2. H_EN=1, H_PERIOD-1=1, H_MASK=8'b10, H_STR=7, H_PHASE=0, flat R=G=B=200 frame of 4 lines → lines 0 and 2 output 200, lines 1 and 3 output 100.
3. V_EN=1, V_PERIOD-1=2, V_MASK=8'b001, V_STR=15, V_PHASE=1, R=255 → pixels at xpos 2, 5, 8 output 0; all others 255.
4. H and V both enabled, H_STR=3, V_STR=11, at a pixel where both hit with c=160 → out = 160 − (160·12>>4) = 40. A pixel with only the H hit → out = 160 − 40 = 120.
5. H_PHASE=5 with H_PERIOD-1=3 (phase out of range) → loads 0, so the line-0 scanline follows H_MASK[0]. reset_n pulsed low mid-line → outputs return to reset values the next cycle, and processing resumes correctly at the next frame.
6. DE_i=0 region with H_STR=15 and all masks set → R/G/B pass through unmodified; x_ph and y_ph hold their values.
